// File: rtl/gbt_rx_mon_pkg.sv
// Shared types and field widths for the GBT RX frame monitor.
package gbt_rx_mon_pkg;

   localparam int FRAME_W     = 84;
   localparam int IC_W        = 2;
   localparam int EC_W        = 2;
   localparam int SEQ_FIELD_W = 8;
   localparam int CMD_W       = 8;
   localparam int PAYLOAD_W   = 64;
   localparam int ERR_CNT_W   = 16;
   localparam int FRAME_CNT_W = 32;
   localparam int DROP_CNT_W  = 16;
   localparam int RUN_W       = 16;   // good/bad run counters

   typedef enum logic [1:0] {
      DOWN,
      HUNT,
      CHECK,
      LOCKED
   } t_mon_state;

   // Field layout of the received frame, MSB first: [83:82] IC, [81:80] EC,
   // [79:72] seq, [71:64] cmd, [63:0] payload.
   typedef struct packed {
      logic [IC_W-1:0]        ic;
      logic [EC_W-1:0]        ec;
      logic [SEQ_FIELD_W-1:0] seq;
      logic [CMD_W-1:0]       cmd;
      logic [PAYLOAD_W-1:0]   payload;
   } t_gbt_frame;

endpackage

// File: rtl/gbt_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over enable.
module gbt_sat_counter
   import gbt_rx_mon_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear first, otherwise step unless already at all-ones.
   always_comb begin
      // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments keep flop updates order-independent.
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_rx_frame_monitor.sv
// GBT RX frame monitor: checks per-frame sequence numbers, locks with
// hysteresis, forwards good frames and counts sequence errors.
// Optional statistics (frame_cnt_o, drop_cnt_o) when GBT_RX_MONITOR_STATS_EN is defined.
module gbt_rx_frame_monitor
   import gbt_rx_mon_pkg::*;
#(
   parameter int SEQ_W         = SEQ_FIELD_W,   // must not exceed SEQ_FIELD_W
   parameter int LOCK_FRAMES   = 16,
   parameter int UNLOCK_ERRORS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   link_ready_i,
   input  logic                   rx_ready_i,
   input  logic                   frame_en_i,
   input  logic [FRAME_W-1:0]     frame_i,
   input  logic                   clear_i,
   output logic                   frame_valid_o,
   output logic [CMD_W-1:0]       cmd_o,
   output logic [PAYLOAD_W-1:0]   payload_o,
   output logic                   locked_o,
   output logic                   seq_error_o,
`ifdef GBT_RX_MONITOR_STATS_EN
   output logic [FRAME_CNT_W-1:0] frame_cnt_o,
   output logic [DROP_CNT_W-1:0]  drop_cnt_o,
`endif
   output logic [ERR_CNT_W-1:0]   err_cnt_o
);

   t_gbt_frame           frame;
   logic                 link_up;
   logic [SEQ_W-1:0]     rx_seq;
   logic [SEQ_W-1:0]     rx_seq_next;
   logic [SEQ_W-1:0]     exp_next;
   logic [RUN_W-1:0]     good_inc;
   logic [RUN_W-1:0]     bad_inc;
   logic                 seq_match;
   logic                 unused_fields;

   t_mon_state           state_q, state_d;
   logic [SEQ_W-1:0]     exp_q, exp_d;
   logic [RUN_W-1:0]     good_q, good_d;
   logic [RUN_W-1:0]     bad_q, bad_d;
   logic                 frame_valid_q, frame_valid_d;
   logic                 seq_error_q, seq_error_d;
   logic [CMD_W-1:0]     cmd_q, cmd_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;

   assign frame         = t_gbt_frame'(frame_i);
   assign unused_fields = ^{frame.ic, frame.ec};
   assign link_up       = link_ready_i & rx_ready_i;
   assign rx_seq        = frame.seq[SEQ_W-1:0];
   assign rx_seq_next   = rx_seq + 1'b1;     // wraps modulo 2^SEQ_W
   assign exp_next      = exp_q + 1'b1;
   assign seq_match     = (rx_seq == exp_q);
   assign good_inc      = good_q + 1'b1;
   assign bad_inc       = bad_q + 1'b1;

   // Lock FSM next state, run counters and registered frame outputs.
   always_comb begin
      state_d       = state_q;
      exp_d         = exp_q;
      good_d        = good_q;
      bad_d         = bad_q;
      frame_valid_d = 1'b0;
      seq_error_d   = 1'b0;
      cmd_d         = cmd_q;
      payload_d     = payload_q;
      if (!link_up) begin
         // Link loss overrides everything; the frame of this cycle is dropped.
         state_d   = DOWN;
         cmd_d     = '0;
         payload_d = '0;
      end else if (state_q == DOWN) begin
         state_d = HUNT;
      end else if (frame_en_i) begin
         unique case (state_q)
            HUNT: begin
               exp_d   = rx_seq_next;
               good_d  = RUN_W'(1);
               bad_d   = '0;
               state_d = (LOCK_FRAMES == 1) ? LOCKED : CHECK;
            end
            CHECK: begin
               if (seq_match) begin
                  exp_d  = exp_next;
                  good_d = good_inc;
                  if (good_inc >= RUN_W'(LOCK_FRAMES)) begin
                     state_d = LOCKED;
                     bad_d   = '0;
                  end
               end else begin
                  seq_error_d = 1'b1;
                  exp_d       = rx_seq_next;
                  good_d      = RUN_W'(1);
               end
            end
            LOCKED: begin
               if (seq_match) begin
                  exp_d         = exp_next;
                  bad_d         = '0;
                  frame_valid_d = 1'b1;
                  cmd_d         = frame.cmd;
                  payload_d     = frame.payload;
               end else begin
                  // Resync on the received number so one dropped frame costs one error.
                  seq_error_d = 1'b1;
                  exp_d       = rx_seq_next;
                  bad_d       = bad_inc;
                  if (bad_inc >= RUN_W'(UNLOCK_ERRORS)) state_d = HUNT;
               end
            end
            default: state_d = DOWN;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= DOWN;
         exp_q         <= '0;
         good_q        <= '0;
         bad_q         <= '0;
         frame_valid_q <= 1'b0;
         seq_error_q   <= 1'b0;
         cmd_q         <= '0;
         payload_q     <= '0;
      end else begin
         state_q       <= state_d;
         exp_q         <= exp_d;
         good_q        <= good_d;
         bad_q         <= bad_d;
         frame_valid_q <= frame_valid_d;
         seq_error_q   <= seq_error_d;
         cmd_q         <= cmd_d;
         payload_q     <= payload_d;
      end
   end

   gbt_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (seq_error_d),
      .clr_i (clear_i),
      .cnt_o (err_cnt_o)
   );

   assign frame_valid_o = frame_valid_q;
   assign seq_error_o   = seq_error_q;
   assign cmd_o         = cmd_q;
   assign payload_o     = payload_q;
   assign locked_o      = (state_q == LOCKED);

`ifdef GBT_RX_MONITOR_STATS_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   lock_lost;

   assign lock_lost = (state_q == LOCKED) && (state_d != LOCKED);

   // Forwarded-frame count: wraps, clear wins.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (clear_i)            frame_cnt_d = '0;
      else if (frame_valid_d) frame_cnt_d = frame_cnt_q + 1'b1;
   end

   // Forwarded-frame count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_cnt_q <= '0;
      else       frame_cnt_q <= frame_cnt_d;
   end

   gbt_sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (lock_lost),
      .clr_i (clear_i),
      .cnt_o (drop_cnt_o)
   );

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_gbt_rx_frame_monitor.sv
// Directed bench for gbt_rx_frame_monitor with a behavioural reference model
// and an every-cycle compare process.
`timescale 1ns/1ps
module tb_gbt_rx_frame_monitor;

   localparam int LOCK_FRAMES   = 16;
   localparam int UNLOCK_ERRORS = 4;
   localparam int M_DOWN = 0, M_HUNT = 1, M_CHECK = 2, M_LOCKED = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        link_ready_i, rx_ready_i, frame_en_i, clear_i;
   logic [83:0] frame_i;
   logic        frame_valid_o, locked_o, seq_error_o;
   logic [7:0]  cmd_o;
   logic [63:0] payload_o;
   logic [15:0] err_cnt_o;
`ifdef GBT_RX_MONITOR_STATS_EN
   logic [31:0] frame_cnt_o;
   logic [15:0] drop_cnt_o;
`endif

   gbt_rx_frame_monitor #(
      .SEQ_W(8), .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_ERRORS(UNLOCK_ERRORS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .link_ready_i  (link_ready_i),
      .rx_ready_i    (rx_ready_i),
      .frame_en_i    (frame_en_i),
      .frame_i       (frame_i),
      .clear_i       (clear_i),
      .frame_valid_o (frame_valid_o),
      .cmd_o         (cmd_o),
      .payload_o     (payload_o),
      .locked_o      (locked_o),
      .seq_error_o   (seq_error_o),
`ifdef GBT_RX_MONITOR_STATS_EN
      .frame_cnt_o   (frame_cnt_o),
      .drop_cnt_o    (drop_cnt_o),
`endif
      .err_cnt_o     (err_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int fidx = 0;

   // Reference model: expected outputs after the most recent clock edge.
   int          m_state, m_exp, m_good, m_bad, m_err, m_drops;
   bit          m_valid, m_seqerr;
   logic [7:0]  m_cmd;
   logic [63:0] m_pay;
   logic [31:0] m_frames;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_DOWN; m_exp = 0; m_good = 0; m_bad = 0; m_err = 0; m_drops = 0;
      m_valid = 0; m_seqerr = 0; m_cmd = '0; m_pay = '0; m_frames = '0;
   endtask

   task automatic model_step(input bit up, input bit en, input int seq,
                             input logic [7:0] cmd, input logic [63:0] pay, input bit clr);
      bit was_locked;
      was_locked = (m_state == M_LOCKED);
      m_valid  = 0;
      m_seqerr = 0;
      if (!up) begin
         m_state = M_DOWN; m_cmd = '0; m_pay = '0;
      end else if (m_state == M_DOWN) begin
         m_state = M_HUNT;
      end else if (en) begin
         if (m_state == M_HUNT) begin
            m_exp = (seq + 1) % 256; m_good = 1; m_bad = 0;
            m_state = (LOCK_FRAMES == 1) ? M_LOCKED : M_CHECK;
         end else if (seq == m_exp) begin
            m_exp = (m_exp + 1) % 256;
            if (m_state == M_CHECK) begin
               m_good++;
               if (m_good >= LOCK_FRAMES) begin m_state = M_LOCKED; m_bad = 0; end
            end else begin
               m_valid = 1; m_cmd = cmd; m_pay = pay; m_bad = 0; m_frames++;
            end
         end else begin
            m_seqerr = 1;
            m_exp = (seq + 1) % 256;
            if (m_state == M_CHECK) m_good = 1;
            else begin
               m_bad++;
               if (m_bad >= UNLOCK_ERRORS) m_state = M_HUNT;
            end
         end
      end
      if (was_locked && m_state != M_LOCKED && m_drops < 65535) m_drops++;
      if (clr) begin
         m_err = 0; m_drops = 0; m_frames = '0;
      end else if (m_seqerr && m_err < 65535) begin
         m_err++;
      end
   endtask

   // One clock of stimulus; inputs change 1 ns after the edge, away from sampling.
   task automatic step(input bit li, input bit ri, input bit en, input int seq, input bit clr);
      logic [7:0]  c;
      logic [63:0] p;
      c = 8'(fidx) ^ 8'h5A;
      p = {32'hDEADBEEF, 32'(fidx)};
      link_ready_i = li; rx_ready_i = ri; frame_en_i = en; clear_i = clr;
      frame_i = {2'b10, 2'b01, 8'(seq), c, p};
      if (en) fidx++;
      @(posedge clk);
      model_step(li & ri, en, seq & 255, c, p, clr);
      #1;
   endtask

   task automatic frame(input int seq);
      step(1, 1, 1, seq, 0);
   endtask

   task automatic idle();
      step(1, 1, 0, 0, 0);
   endtask

   // Compare process: every cycle, on the falling edge.
   always @(negedge clk) begin
      check("frame_valid", 64'(frame_valid_o), 64'(m_valid));
      check("locked", 64'(locked_o), 64'(m_state == M_LOCKED));
      check("seq_error", 64'(seq_error_o), 64'(m_seqerr));
      check("err_cnt", 64'(err_cnt_o), 64'(m_err));
      if (m_valid) begin
         check("cmd", 64'(cmd_o), 64'(m_cmd));
         check("payload", payload_o, m_pay);
      end
`ifdef GBT_RX_MONITOR_STATS_EN
      check("frame_cnt", 64'(frame_cnt_o), 64'(m_frames));
      check("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
`endif
   end

   initial begin
      reset = 1'b1;
      link_ready_i = 0; rx_ready_i = 0; frame_en_i = 0; clear_i = 0; frame_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked", 64'(locked_o), 64'd0);
      check("rst_valid", 64'(frame_valid_o), 64'd0);
      check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
      reset = 1'b0;

      // 1: acquire lock on seq 0..19, one idle gap in the middle.
      idle();
      for (int s = 0; s < 20; s++) begin
         if (s == 6) idle();
         frame(s);
         if (s == 14) check("t1_not_locked_15", 64'(locked_o), 64'd0);
         if (s == 15) begin
            check("t1_locked_16", 64'(locked_o), 64'd1);
            check("t1_lock_frame_not_fwd", 64'(frame_valid_o), 64'd0);
         end
         if (s == 16) begin
            check("t1_fwd_valid", 64'(frame_valid_o), 64'd1);
            check("t1_fwd_payload", payload_o, 64'hDEADBEEF_00000010);
            check("t1_fwd_cmd", 64'(cmd_o), 64'h4A);
         end
      end
      idle();
      check("t1_idle_valid", 64'(frame_valid_o), 64'd0);

      // 2: run through 0xFE, 0xFF, 0x00, 0x01.
      for (int s = 20; s < 258; s++) frame(s);
      check("t2_wrap_err_cnt", 64'(err_cnt_o), 64'd0);
      check("t2_wrap_valid", 64'(frame_valid_o), 64'd1);

      // 3: single skipped number (7 missing).
      for (int s = 2; s <= 6; s++) frame(s);
      frame(8);
      check("t3_seq_error", 64'(seq_error_o), 64'd1);
      check("t3_drop_not_fwd", 64'(frame_valid_o), 64'd0);
      frame(9);
      check("t3_resync_fwd", 64'(frame_valid_o), 64'd1);
      check("t3_err_cnt", 64'(err_cnt_o), 64'd1);
      check("t3_still_locked", 64'(locked_o), 64'd1);

      // 4: four consecutive mismatches unlock.
      frame(20); frame(30); frame(40);
      check("t4_locked_after_3", 64'(locked_o), 64'd1);
      frame(50);
      check("t4_unlocked", 64'(locked_o), 64'd0);
      check("t4_err_cnt", 64'(err_cnt_o), 64'd5);

      // 5: relock, then a one-cycle rx_ready drop.
      for (int s = 100; s <= 116; s++) frame(s);
      check("t5_relocked", 64'(locked_o), 64'd1);
      step(1, 0, 1, 117, 0);
      check("t5_drop_valid", 64'(frame_valid_o), 64'd0);
      check("t5_drop_locked", 64'(locked_o), 64'd0);
`ifdef GBT_RX_MONITOR_STATS_EN
      check("t5_drop_cnt", 64'(drop_cnt_o), 64'd1);
`endif
      idle();
      for (int s = 0; s < 16; s++) begin
         frame(s);
         if (s == 14) check("t5_relock_not_yet", 64'(locked_o), 64'd0);
      end
      check("t5_relock_16", 64'(locked_o), 64'd1);

      // 6: saturate the error counter from CHECK, then clear against an error.
      step(1, 0, 0, 0, 0);
      idle();
      frame(0);
      for (int i = 0; i < 65540; i++) frame(0);
      check("t6_err_sat", 64'(err_cnt_o), 64'hFFFF);
      frame(0); frame(0); frame(0);
      check("t6_err_held", 64'(err_cnt_o), 64'hFFFF);
      step(1, 1, 1, 0, 1);
      check("t6_clear_wins", 64'(err_cnt_o), 64'd0);
      check("t6_clear_pulse", 64'(seq_error_o), 64'd1);
      frame(0);
      check("t6_count_after_clear", 64'(err_cnt_o), 64'd1);

      // Asynchronous reset between edges.
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_rst_err_cnt", 64'(err_cnt_o), 64'd0);
      check("async_rst_seq_error", 64'(seq_error_o), 64'd0);
      check("async_rst_locked", 64'(locked_o), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
